// File: rtl/irq_sched_pkg.sv
// irq_sched_pkg: shared register map, source indices and FSM encoding for periph_irq_sched.
package irq_sched_pkg;

    localparam logic [1:0] REG_PENDING  = 2'd0;
    localparam logic [1:0] REG_ENABLE   = 2'd1;
    localparam logic [1:0] REG_CLAIM    = 2'd2;
    localparam logic [1:0] REG_COMPLETE = 2'd3;

    localparam int SRC_TIMER = 0;
    localparam int SRC_I2C   = 1;
    localparam int SRC_CRC   = 2;
    localparam int SRC_UART  = 3;

    localparam int CLAIM_VALID_BIT = 7;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        SERVICE = 1'b1
    } state_e;

endpackage

// File: rtl/periph_irq_sched_pick.sv
// irq_pick: combinational winner search over the candidate vector, starting at a given index
// and wrapping modulo NUM_SRC; a start of 0 gives fixed lowest-index priority.
module irq_pick
    import irq_sched_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 3
) (
    input  logic [NUM_SRC-1:0] cand,
    input  logic [ID_W-1:0]    start,
    output logic [ID_W-1:0]    winner,
    output logic               found
);

    localparam int IW   = ID_W + 1;
    localparam int SPAN = 1 << ID_W;

    logic [SPAN-1:0] cand_ext_s;
    logic [IW-1:0]   idx_s;

    // Scan every source once from the start index, first set candidate wins.
    always_comb begin
        winner     = '0;
        found      = 1'b0;
        idx_s      = '0;
        cand_ext_s = '0;
        cand_ext_s[NUM_SRC-1:0] = cand;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx_s = {1'b0, start} + IW'(k);
            if (idx_s >= IW'(NUM_SRC)) begin
                idx_s = idx_s - IW'(NUM_SRC);
            end else begin
                idx_s = idx_s;
            end
            if (!found && cand_ext_s[idx_s[ID_W-1:0]]) begin
                winner = idx_s[ID_W-1:0];
                found  = 1'b1;
            end else begin
                winner = winner;
                found  = found;
            end
        end
    end

endmodule

// File: rtl/periph_irq_sched.sv
// periph_irq_sched: latches peripheral interrupt edges, masks them and serves one at a time via
// CLAIM/COMPLETE registers. Define IRQ_SCHED_RR_EN for round-robin instead of fixed priority.
module periph_irq_sched
    import irq_sched_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] src_irq,
    input  logic [1:0]         reg_addr,
    input  logic [7:0]         reg_wdata,
    input  logic               reg_we,
    input  logic               reg_re,
    output logic [7:0]         reg_rdata,
    output logic               reg_rvalid,
    output logic               cpu_irq,
    output logic [ID_W-1:0]    active_id
);

    logic [NUM_SRC-1:0] prev_src_r;
    logic [NUM_SRC-1:0] pending_r;
    logic [NUM_SRC-1:0] enable_r;
    state_e             state_r;
    logic [ID_W-1:0]    active_id_r;
    logic               cpu_irq_r;
    logic [7:0]         rdata_r;
    logic               rvalid_r;

    logic [NUM_SRC-1:0] rise_s;
    logic [NUM_SRC-1:0] cand_s;
    logic [NUM_SRC-1:0] w1c_mask_s;
    logic [NUM_SRC-1:0] claim_mask_s;
    logic [NUM_SRC-1:0] pending_nxt_s;
    logic [NUM_SRC-1:0] enable_nxt_s;
    logic [ID_W-1:0]    start_s;
    logic [ID_W-1:0]    winner_s;
    logic               found_s;
    logic               claim_ok_s;
    logic               complete_ok_s;
    state_e             state_nxt_s;
    logic [ID_W-1:0]    active_id_nxt_s;
    logic               cpu_irq_nxt_s;
    logic [7:0]         claim_word_s;
    logic [7:0]         rdata_nxt_s;
    logic               unused_wdata_s;

    assign rise_s = src_irq & ~prev_src_r;
    assign cand_s = pending_r & enable_r;
    assign unused_wdata_s = ^reg_wdata;

    irq_pick #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_pick (
        .cand    (cand_s),
        .start   (start_s),
        .winner  (winner_s),
        .found   (found_s)
    );

`ifdef IRQ_SCHED_RR_EN
    logic [ID_W-1:0] last_grant_r;

    // Search begins just after the most recently granted source so no source can starve the rest.
    always_comb begin
        if (last_grant_r >= ID_W'(NUM_SRC - 1)) begin
            start_s = '0;
        end else begin
            start_s = last_grant_r + ID_W'(1);
        end
    end

    // Remember the source granted on each successful claim.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_r <= '0;
        end else if (claim_ok_s) begin
            last_grant_r <= winner_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`else
    assign start_s = ID_W'(SRC_TIMER);
`endif

    // Register-window side effects on the pending and enable vectors.
    always_comb begin
        claim_ok_s    = reg_re && (reg_addr == REG_CLAIM) && (state_r == IDLE) && found_s;
        complete_ok_s = reg_we && (reg_addr == REG_COMPLETE) && (state_r == SERVICE)
                        && (reg_wdata[ID_W-1:0] == active_id_r);
        if (reg_we && (reg_addr == REG_PENDING)) begin
            w1c_mask_s = reg_wdata[NUM_SRC-1:0];
        end else begin
            w1c_mask_s = '0;
        end
        if (claim_ok_s) begin
            claim_mask_s = NUM_SRC'(1) << winner_s;
        end else begin
            claim_mask_s = '0;
        end
        if (reg_we && (reg_addr == REG_ENABLE)) begin
            enable_nxt_s = reg_wdata[NUM_SRC-1:0];
        end else begin
            enable_nxt_s = enable_r;
        end
        // A fresh rising edge always survives a clear in the same cycle.
        pending_nxt_s = (pending_r & ~w1c_mask_s & ~claim_mask_s) | rise_s;
    end

    // Service FSM: one interrupt in service at a time, no nesting.
    always_comb begin
        state_nxt_s     = state_r;
        active_id_nxt_s = active_id_r;
        case (state_r)
            IDLE: begin
                if (claim_ok_s) begin
                    state_nxt_s     = SERVICE;
                    active_id_nxt_s = winner_s + ID_W'(1);
                end else begin
                    state_nxt_s     = IDLE;
                    active_id_nxt_s = '0;
                end
            end
            SERVICE: begin
                if (complete_ok_s) begin
                    state_nxt_s     = IDLE;
                    active_id_nxt_s = '0;
                end else begin
                    state_nxt_s     = SERVICE;
                    active_id_nxt_s = active_id_r;
                end
            end
            default: begin
                state_nxt_s     = IDLE;
                active_id_nxt_s = '0;
            end
        endcase
        cpu_irq_nxt_s = (state_nxt_s == IDLE) && (|cand_s);
    end

    // Read mux samples pre-write state; data holds until the next read.
    always_comb begin
        claim_word_s = 8'h00;
        if ((state_r == IDLE) && found_s) begin
            claim_word_s[CLAIM_VALID_BIT] = 1'b1;
            claim_word_s[ID_W-1:0]        = winner_s + ID_W'(1);
        end else begin
            claim_word_s = 8'h00;
        end
        rdata_nxt_s = rdata_r;
        if (reg_re) begin
            case (reg_addr)
                REG_PENDING: rdata_nxt_s = 8'(pending_r);
                REG_ENABLE:  rdata_nxt_s = 8'(enable_r);
                REG_CLAIM:   rdata_nxt_s = claim_word_s;
                default:     rdata_nxt_s = 8'h00;
            endcase
        end else begin
            rdata_nxt_s = rdata_r;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_src_r  <= '0;
            pending_r   <= '0;
            enable_r    <= '0;
            state_r     <= IDLE;
            active_id_r <= '0;
            cpu_irq_r   <= 1'b0;
            rdata_r     <= 8'h00;
            rvalid_r    <= 1'b0;
        end else begin
            prev_src_r  <= src_irq;
            pending_r   <= pending_nxt_s;
            enable_r    <= enable_nxt_s;
            state_r     <= state_nxt_s;
            active_id_r <= active_id_nxt_s;
            cpu_irq_r   <= cpu_irq_nxt_s;
            rdata_r     <= rdata_nxt_s;
            rvalid_r    <= reg_re;
        end
    end

    assign reg_rdata  = rdata_r;
    assign reg_rvalid = rvalid_r;
    assign cpu_irq    = cpu_irq_r;
    assign active_id  = active_id_r;

endmodule

// File: tb/tb_periph_irq_sched.sv
// tb_periph_irq_sched: cycle-stepped vector table with a read-data scoreboard, plus a reset-mid-service sequence.
module tb_periph_irq_sched;

    localparam int NUM_SRC = 4;
    localparam int ID_W    = 3;
    localparam logic [1:0] A_PEND = 2'd0;
    localparam logic [1:0] A_EN   = 2'd1;
    localparam logic [1:0] A_CL   = 2'd2;
    localparam logic [1:0] A_CP   = 2'd3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NUM_SRC-1:0] src_irq;
    logic [1:0]         reg_addr;
    logic [7:0]         reg_wdata;
    logic               reg_we;
    logic               reg_re;
    logic [7:0]         reg_rdata;
    logic               reg_rvalid;
    logic               cpu_irq;
    logic [ID_W-1:0]    active_id;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    typedef struct {
        logic [3:0] src;
        logic       we;
        logic       re;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic [7:0] rd;
        logic       irq;
        logic [2:0] id;
    } vec_t;

    vec_t tbl[$];

    periph_irq_sched #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_irq    (src_irq),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_we     (reg_we),
        .reg_re     (reg_re),
        .reg_rdata  (reg_rdata),
        .reg_rvalid (reg_rvalid),
        .cpu_irq    (cpu_irq),
        .active_id  (active_id)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic [3:0] src, logic we, logic re, logic [1:0] addr,
                                logic [7:0] wdata, logic [7:0] rd, logic irq, logic [2:0] id);
        vec_t v;
        v.src = src; v.we = we; v.re = re; v.addr = addr;
        v.wdata = wdata; v.rd = rd; v.irq = irq; v.id = id;
        return v;
    endfunction

    task automatic chk(string name, int step_no, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL step %0d %s: got %0h expected %0h", step_no, name, act, exp);
        end
    endtask

    task automatic step(int n, vec_t v);
        src_irq   = v.src;
        reg_we    = v.we;
        reg_re    = v.re;
        reg_addr  = v.addr;
        reg_wdata = v.wdata;
        if (v.re) exp_q.push_back(v.rd);
        @(posedge clk);
        #1;
        reg_we = 1'b0;
        reg_re = 1'b0;
        chk("cpu_irq", n, 8'(cpu_irq), 8'(v.irq));
        chk("active_id", n, 8'(active_id), 8'(v.id));
        chk("rvalid", n, 8'(reg_rvalid), 8'(v.re));
    endtask

    // Scoreboard: every read response is matched against the next queued expectation.
    always @(negedge clk) begin
        if (reg_rvalid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rdata_unexpected: got %0h expected no response", reg_rdata);
            end else begin
                mon_exp = exp_q.pop_front();
                if (reg_rdata !== mon_exp) begin
                    errors++;
                    $display("FAIL rdata: got %0h expected %0h", reg_rdata, mon_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // basic timer service
        tbl.push_back(mk(4'h0, 1'b1, 1'b0, A_EN,   8'h0F, 8'h00, 1'b0, 3'd0));
        tbl.push_back(mk(4'h1, 1'b0, 1'b0, A_PEND, 8'h00, 8'h00, 1'b0, 3'd0));
        tbl.push_back(mk(4'h0, 1'b0, 1'b0, A_PEND, 8'h00, 8'h00, 1'b1, 3'd0));
        tbl.push_back(mk(4'h0, 1'b0, 1'b1, A_CL,   8'h00, 8'h81, 1'b0, 3'd1));
        tbl.push_back(mk(4'h0, 1'b1, 1'b0, A_CP,   8'h01, 8'h00, 1'b0, 3'd0));
        // coincident edges on timer, I2C, CRC
        tbl.push_back(mk(4'h7, 1'b0, 1'b0, A_PEND, 8'h00, 8'h00, 1'b0, 3'd0));
        tbl.push_back(mk(4'h0, 1'b0, 1'b0, A_PEND, 8'h00, 8'h00, 1'b1, 3'd0));
        tbl.push_back(mk(4'h0, 1'b0, 1'b1, A_CL,   8'h00, 8'h81, 1'b0, 3'd1));
        tbl.push_back(mk(4'h0, 1'b1, 1'b0, A_CP,   8'h01, 8'h00, 1'b1, 3'd0));
        tbl.push_back(mk(4'h0, 1'b0, 1'b1, A_CL,   8'h00, 8'h82, 1'b0, 3'd2));
        tbl.push_back(mk(4'h0, 1'b1, 1'b0, A_CP,   8'h02, 8'h00, 1'b1, 3'd0));
        tbl.push_back(mk(4'h0, 1'b0, 1'b1, A_CL,   8'h00, 8'h83, 1'b0, 3'd3));
        tbl.push_back(mk(4'h0, 1'b1, 1'b0, A_CP,   8'h03, 8'h00, 1'b0, 3'd0));
        // masking
        tbl.push_back(mk(4'h0, 1'b1, 1'b0, A_EN,   8'h02, 8'h00, 1'b0, 3'd0));
        tbl.push_back(mk(4'h4, 1'b0, 1'b0, A_PEND, 8'h00, 8'h00, 1'b0, 3'd0));
        tbl.push_back(mk(4'h0, 1'b0, 1'b0, A_PEND, 8'h00, 8'h00, 1'b0, 3'd0));
        tbl.push_back(mk(4'h0, 1'b0, 1'b1, A_PEND, 8'h00, 8'h04, 1'b0, 3'd0));
        tbl.push_back(mk(4'h0, 1'b1, 1'b0, A_EN,   8'h06, 8'h00, 1'b0, 3'd0));
        tbl.push_back(mk(4'h0, 1'b0, 1'b0, A_PEND, 8'h00, 8'h00, 1'b1, 3'd0));
        tbl.push_back(mk(4'h0, 1'b0, 1'b1, A_CL,   8'h00, 8'h83, 1'b0, 3'd3));
        tbl.push_back(mk(4'h0, 1'b1, 1'b0, A_CP,   8'h03, 8'h00, 1'b0, 3'd0));
        // service protection
        tbl.push_back(mk(4'h2, 1'b0, 1'b0, A_PEND, 8'h00, 8'h00, 1'b0, 3'd0));
        tbl.push_back(mk(4'h0, 1'b1, 1'b0, A_EN,   8'h0F, 8'h00, 1'b1, 3'd0));
        tbl.push_back(mk(4'h0, 1'b0, 1'b1, A_CL,   8'h00, 8'h82, 1'b0, 3'd2));
        tbl.push_back(mk(4'h1, 1'b0, 1'b0, A_PEND, 8'h00, 8'h00, 1'b0, 3'd2));
        tbl.push_back(mk(4'h0, 1'b0, 1'b1, A_CL,   8'h00, 8'h00, 1'b0, 3'd2));
        tbl.push_back(mk(4'h0, 1'b1, 1'b0, A_CP,   8'h01, 8'h00, 1'b0, 3'd2));
        tbl.push_back(mk(4'h0, 1'b0, 1'b1, A_PEND, 8'h00, 8'h01, 1'b0, 3'd2));
        tbl.push_back(mk(4'h0, 1'b1, 1'b0, A_CP,   8'h02, 8'h00, 1'b1, 3'd0));
        tbl.push_back(mk(4'h0, 1'b0, 1'b1, A_CL,   8'h00, 8'h81, 1'b0, 3'd1));
        tbl.push_back(mk(4'h0, 1'b1, 1'b0, A_CP,   8'h01, 8'h00, 1'b0, 3'd0));
        // empty claim, W1C vs rise, W1C clearing
        tbl.push_back(mk(4'h0, 1'b0, 1'b1, A_CL,   8'h00, 8'h00, 1'b0, 3'd0));
        tbl.push_back(mk(4'h0, 1'b0, 1'b1, A_PEND, 8'h00, 8'h00, 1'b0, 3'd0));
        tbl.push_back(mk(4'h2, 1'b1, 1'b1, A_PEND, 8'h02, 8'h00, 1'b0, 3'd0));
        tbl.push_back(mk(4'h0, 1'b0, 1'b1, A_PEND, 8'h00, 8'h02, 1'b1, 3'd0));
        tbl.push_back(mk(4'h0, 1'b1, 1'b0, A_PEND, 8'h02, 8'h00, 1'b1, 3'd0));
        tbl.push_back(mk(4'h0, 1'b0, 1'b1, A_PEND, 8'h00, 8'h00, 1'b0, 3'd0));
        // claim and new rise on the claimed source together
        tbl.push_back(mk(4'h1, 1'b0, 1'b0, A_PEND, 8'h00, 8'h00, 1'b0, 3'd0));
        tbl.push_back(mk(4'h0, 1'b0, 1'b0, A_PEND, 8'h00, 8'h00, 1'b1, 3'd0));
        tbl.push_back(mk(4'h1, 1'b0, 1'b1, A_CL,   8'h00, 8'h81, 1'b0, 3'd1));
        tbl.push_back(mk(4'h0, 1'b1, 1'b0, A_CP,   8'h01, 8'h00, 1'b1, 3'd0));
        tbl.push_back(mk(4'h0, 1'b0, 1'b1, A_CL,   8'h00, 8'h81, 1'b0, 3'd1));
        tbl.push_back(mk(4'h0, 1'b1, 1'b0, A_CP,   8'h01, 8'h00, 1'b0, 3'd0));
        // simultaneous read/write returns old value; upper bits ignored
        tbl.push_back(mk(4'h0, 1'b1, 1'b1, A_EN,   8'h03, 8'h0F, 1'b0, 3'd0));
        tbl.push_back(mk(4'h0, 1'b0, 1'b1, A_EN,   8'h00, 8'h03, 1'b0, 3'd0));
        tbl.push_back(mk(4'h0, 1'b1, 1'b0, A_EN,   8'hF3, 8'h00, 1'b0, 3'd0));
        tbl.push_back(mk(4'h0, 1'b0, 1'b1, A_EN,   8'h00, 8'h03, 1'b0, 3'd0));

        rst_n = 1'b0; src_irq = '0; reg_addr = 2'd0; reg_wdata = 8'h00; reg_we = 1'b0; reg_re = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_cpu_irq", -1, 8'(cpu_irq), 8'h00);
        chk("reset_active_id", -1, 8'(active_id), 8'h00);
        chk("reset_rvalid", -1, 8'(reg_rvalid), 8'h00);
        chk("reset_rdata", -1, reg_rdata, 8'h00);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) step(i, tbl[i]);

        // reset asserted while source 2 (ID 3) is in service
        step(100, mk(4'h0, 1'b1, 1'b0, A_EN,   8'h0F, 8'h00, 1'b0, 3'd0));
        step(101, mk(4'h4, 1'b0, 1'b0, A_PEND, 8'h00, 8'h00, 1'b0, 3'd0));
        step(102, mk(4'h0, 1'b0, 1'b0, A_PEND, 8'h00, 8'h00, 1'b1, 3'd0));
        step(103, mk(4'h0, 1'b0, 1'b1, A_CL,   8'h00, 8'h83, 1'b0, 3'd3));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_cpu_irq", 104, 8'(cpu_irq), 8'h00);
        chk("midrst_active_id", 104, 8'(active_id), 8'h00);
        chk("midrst_rvalid", 104, 8'(reg_rvalid), 8'h00);
        chk("midrst_rdata", 104, reg_rdata, 8'h00);
        rst_n = 1'b1;
        step(105, mk(4'h0, 1'b0, 1'b1, A_PEND, 8'h00, 8'h00, 1'b0, 3'd0));
        step(106, mk(4'h0, 1'b0, 1'b1, A_EN,   8'h00, 8'h00, 1'b0, 3'd0));
        step(107, mk(4'h2, 1'b0, 1'b0, A_PEND, 8'h00, 8'h00, 1'b0, 3'd0));
        step(108, mk(4'h0, 1'b0, 1'b0, A_PEND, 8'h00, 8'h00, 1'b0, 3'd0));
        step(109, mk(4'h0, 1'b0, 1'b1, A_CL,   8'h00, 8'h00, 1'b0, 3'd0));

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", 110, 8'(exp_q.size()), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/periph_irq_sched.md
Name: periph_irq_sched

Overview:
- Interrupt scheduler between the tinyQV core and its interrupt-generating peripherals: timer, I2C master, CRC engine, UART.
- Latches peripheral interrupt edges, masks them, and selects one winner.
- Presents a single non-nesting interrupt line to the CPU, plus a small register window for claim/complete.
- Guarantees deterministic service order when timer, I2C and CRC events coincide.

Parameters:
- NUM_SRC, 4, number of interrupt sources. Index 0 = timer, 1 = I2C, 2 = CRC, 3 = UART. Legal range 1..7.
- ID_W, 3, width of the source ID field. Must satisfy 2^ID_W > NUM_SRC.

Ports:
- clk, in, 1, core clock.
- rst_n, in, 1, synchronous active-low reset.
- src_irq, in, NUM_SRC, peripheral interrupt requests. Level or pulse; only rising edges are used.
- reg_addr, in, 2, register select.
- reg_wdata, in, 8, write data.
- reg_we, in, 1, write strobe, single cycle.
- reg_re, in, 1, read strobe, single cycle.
- reg_rdata, out, 8, read data, registered.
- reg_rvalid, out, 1, high one cycle after reg_re.
- cpu_irq, out, 1, interrupt request to the core.
- active_id, out, ID_W, ID of the source currently in service. 0 when none.

Behaviour:
- Reset state: all outputs 0; pending, enable, prev_src and in-service state all 0; FSM in IDLE.
- Edge detect:
  - prev_src <= src_irq every cycle.
  - rise = src_irq & ~prev_src.
  - pending[i] <= 1 on rise[i]. A source held high counts as one edge.
- Register map:
  - 0 PENDING: read returns pending. Write-1-to-clear.
  - 1 ENABLE: read/write mask, bit i enables source i.
  - 2 CLAIM: read returns {1'b1 valid, zeros, id+1} for the winner, or 0x00 if no candidate.
  - 3 COMPLETE: write of an ID (1..NUM_SRC) ends service.
- Candidates and winner:
  - cand = pending & enable.
  - Winner is the lowest set index of cand (fixed priority, timer highest).
- FSM states:
  - IDLE: cpu_irq = |cand. A CLAIM read with |cand clears pending[winner], sets active_id = winner+1 and goes to SERVICE. A CLAIM read with cand = 0 returns 0x00 and the FSM stays in IDLE.
  - SERVICE: cpu_irq = 0 (no nesting). A CLAIM read returns 0x00 with no side effect. A COMPLETE write whose wdata[ID_W-1:0] equals active_id returns to IDLE with active_id = 0. A mismatched ID is ignored.
  - cpu_irq is registered: it asserts the cycle after cand becomes non-zero in IDLE.
- Read latency: reg_rdata and reg_rvalid are valid exactly 1 cycle after reg_re. reg_rdata holds its value until the next read.
- Simultaneous events:
  - Rise and W1C on the same bit in the same cycle: the set wins.
  - Claim read and a new rise on the claimed source in the same cycle: pending stays set, and a second service follows later.
  - reg_we and reg_re in the same cycle: both act. The read returns the pre-write value.
- Sources in service keep latching new edges. Pending is not blocked by active_id.
- Writes to ENABLE take effect on cand in the next cycle.
- rst_n low mid-service: everything returns to reset state next clock. Edges arriving during reset are lost.
- Out-of-range COMPLETE IDs and writes to bits >= NUM_SRC are ignored. Reads of those bits return 0.

Optional Feature:
- Macro: IRQ_SCHED_RR_EN.
- Defined:
  - Round-robin selection. A last_grant pointer (reset 0) is updated on each successful claim.
  - The search starts at last_grant+1 modulo NUM_SRC.
  - This prevents a fast timer from starving I2C and CRC.
- Undefined:
  - Fixed lowest-index priority.
  - No pointer register is synthesised.

Decomposition:
- Shared package irq_sched_pkg holds:
  - register address constants (REG_PENDING = 0, REG_ENABLE = 1, REG_CLAIM = 2, REG_COMPLETE = 3);
  - source index constants (SRC_TIMER, SRC_I2C, SRC_CRC, SRC_UART);
  - CLAIM_VALID_BIT = 7;
  - the FSM state enum {IDLE, SERVICE}.
- One sub-module, irq_pick: purely combinational selector. Inputs are cand and a start index (tied to 0 in fixed mode). Outputs are winner and found.

Test Plan:
- Basic timer service: ENABLE = 0x0F, pulse src_irq[0] -> cpu_irq = 1 two cycles later. CLAIM read = 0x81, cpu_irq = 0, active_id = 1. COMPLETE write 0x01 -> active_id = 0.
- Coincident edges: rises on sources 0, 1 and 2 in the same cycle -> claims return 0x81, then 0x82, then 0x83, each after its COMPLETE. With IRQ_SCHED_RR_EN and last_grant = 0, a second coincident burst returns 0x82, 0x83, 0x81.
- Masking: ENABLE = 0x02, edge on source 2 -> cpu_irq stays 0 and PENDING reads 0x04. ENABLE = 0x06 -> cpu_irq = 1 and claim returns 0x83.
- Service protection: during service of ID 2, an edge on source 0 -> cpu_irq stays 0, CLAIM returns 0x00, COMPLETE 0x01 is ignored. COMPLETE 0x02 -> cpu_irq rises and claim returns 0x81.
- Boundaries: W1C and rise on bit 1 in the same cycle -> PENDING bit 1 = 1. CLAIM with nothing pending -> 0x00 and no state change.
- Reset mid-service: rst_n low for 1 cycle while active_id = 3 -> all registers 0, cpu_irq = 0, reg_rvalid = 0.
